clk_div_multi: RTL and testbench

//   Programmable clock divider / tick generator, successor to the two-rate divider.

---
 rtl/clk_div_multi_pkg.sv | 19 +
 rtl/clk_div_multi_lut.sv | 32 +++
 rtl/clk_div_multi.sv | 97 +++++++++
 tb/tb_clk_div_multi.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared rate codes and helpers for the multi-rate clock divider.
package clk_div_multi_pkg;

  // rate_sel encodings
  localparam logic [2:0] RATE_P0     = 3'd0;
  localparam logic [2:0] RATE_P1     = 3'd1;
  localparam logic [2:0] RATE_P2     = 3'd2;
  localparam logic [2:0] RATE_P3     = 3'd3;
  localparam logic [2:0] RATE_CUSTOM = 3'd4;

  // Smallest divisor that still yields one low and one high cycle.
  localparam int MIN_DIV = 2;

  // Codes above RATE_CUSTOM are unused and fall back to the slowest preset.
  function automatic logic [2:0] map_rate(input logic [2:0] sel);
    return (sel > RATE_CUSTOM) ? RATE_P0 : sel;
  endfunction

endpackage

// File: rtl/clk_div_multi_lut.sv
// Combinational divisor lookup: rate code -> clamped divisor and mapped code.
module clk_div_lut
  import clk_div_multi_pkg::*;
#(
  parameter int CNT_W = 23,
  parameter int DIV0  = 5000000,
  parameter int DIV1  = 2000000,
  parameter int DIV2  = 1000000,
  parameter int DIV3  = 500000
) (
  input  logic [2:0]       rate_sel_i,
  input  logic [CNT_W-1:0] div_custom_i,
  output logic [CNT_W-1:0] div_o,
  output logic [2:0]       rate_o
);

  logic [CNT_W-1:0] raw_div;

  // Pick the divisor for the mapped code, then clamp so the output always toggles.
  always_comb begin
    rate_o = map_rate(rate_sel_i);
    unique case (rate_o)
      RATE_P1:     raw_div = CNT_W'(DIV1);
      RATE_P2:     raw_div = CNT_W'(DIV2);
      RATE_P3:     raw_div = CNT_W'(DIV3);
      RATE_CUSTOM: raw_div = div_custom_i;
      default:     raw_div = CNT_W'(DIV0);
    endcase
    div_o = (raw_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : raw_div;
  end

endmodule

// File: rtl/clk_div_multi.sv
// Programmable clock divider / tick generator. Rate changes are latched only
// on the period wrap, so clk_out never produces a short or long glitch phase.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int CNT_W = 23,
  parameter int DIV0  = 5000000,
  parameter int DIV1  = 2000000,
  parameter int DIV2  = 1000000,
  parameter int DIV3  = 500000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       rate_sel,
  input  logic [CNT_W-1:0] div_custom,
  output logic             clk_out,
  output logic             tick,
  output logic             led,
  output logic [2:0]       rate_act
);

  logic [CNT_W-1:0] lut_div;
  logic [2:0]       lut_rate;

  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] div_act_q,  div_act_d;
  logic [2:0]       rate_act_q, rate_act_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             led_q,      led_d;
  logic             wrap;

  clk_div_lut #(
    .CNT_W (CNT_W),
    .DIV0  (DIV0),
    .DIV1  (DIV1),
    .DIV2  (DIV2),
    .DIV3  (DIV3)
  ) u_lut (
    .rate_sel_i   (rate_sel),
    .div_custom_i (div_custom),
    .div_o        (lut_div),
    .rate_o       (lut_rate)
  );

  // >= rather than == so a divisor that shrank below cnt still wraps promptly.
  assign wrap = (cnt_q >= div_act_q);

  // Next-state: advance or wrap when enabled, otherwise hold everything but tick.
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    rate_act_d = rate_act_q;
    clk_out_d  = clk_out_q;
    led_d      = led_q;
    tick_d     = 1'b0;
    if (en) begin
      if (wrap) begin
        cnt_d      = CNT_W'(1);
        div_act_d  = lut_div;
        rate_act_d = lut_rate;
        tick_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Low for the first floor(D/2) counts, high for the rest of the period.
      clk_out_d = (cnt_q > (div_act_q >> 1));
      led_d     = clk_out_q;
    end
  end

  // State registers; reset restarts a full period under the current selection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= CNT_W'(1);
      div_act_q  <= lut_div;
      rate_act_q <= lut_rate;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      rate_act_q <= rate_act_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      led_q      <= led_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign led      = led_q;
  assign rate_act = rate_act_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with small divisors (10/4/7/2, CNT_W=8).
module tb_clk_div_multi;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       rate_sel;
  logic [CNT_W-1:0] div_custom;
  logic             clk_out;
  logic             tick;
  logic             led;
  logic [2:0]       rate_act;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_clk;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(
    .CNT_W (CNT_W),
    .DIV0  (10),
    .DIV1  (4),
    .DIV2  (7),
    .DIV3  (2)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .rate_sel   (rate_sel),
    .div_custom (div_custom),
    .clk_out    (clk_out),
    .tick       (tick),
    .led        (led),
    .rate_act   (rate_act)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // One enabled edge: check outputs; led must echo the previous clk_out.
  task automatic edge_chk(input logic e_clk, input logic e_tick, input logic [2:0] e_rate);
    @(posedge clk_in); #1;
    chk("clk_out",  clk_out,  e_clk);
    chk("tick",     tick,     e_tick);
    chk("led",      led,      prev_clk);
    chk("rate_act", rate_act, e_rate);
    prev_clk = e_clk;
  endtask

  // Run from count 'first' through the wrap of a D-cycle period.
  task automatic period(input int d, input int first, input logic [2:0] rb, input logic [2:0] ra);
    for (int c = first; c <= d; c++)
      edge_chk(c > d / 2, c == d, (c == d) ? ra : rb);
  endtask

  initial begin
    prev_clk   = 1'b0;
    rst        = 1'b1;
    en         = 1'b1;
    rate_sel   = 3'd0;
    div_custom = '0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_clk_out",  clk_out,  1'b0);
    chk("rst_tick",     tick,     1'b0);
    chk("rst_led",      led,      1'b0);
    chk("rst_rate_act", rate_act, 3'd0);
    rst = 1'b0;

    // 1: divide by 10, two full periods
    period(10, 1, 3'd0, 3'd0);
    period(10, 1, 3'd0, 3'd0);

    // 2: switch to preset 1 at cnt=3; current period completes first
    edge_chk(1'b0, 1'b0, 3'd0);
    edge_chk(1'b0, 1'b0, 3'd0);
    rate_sel = 3'd1;
    period(10, 3, 3'd0, 3'd1);
    period(4, 1, 3'd1, 3'd1);
    period(4, 1, 3'd1, 3'd1);

    // 3: odd divisor 7 (3 low / 4 high), then divisor 2
    rate_sel = 3'd2;
    period(4, 1, 3'd1, 3'd2);
    period(7, 1, 3'd2, 3'd2);
    rate_sel = 3'd3;
    period(7, 1, 3'd2, 3'd3);
    period(2, 1, 3'd3, 3'd3);
    period(2, 1, 3'd3, 3'd3);

    // 4: custom divisor 0 and 1 clamp to 2; then 200
    rate_sel   = 3'd4;
    div_custom = 8'd0;
    period(2, 1, 3'd3, 3'd4);
    period(2, 1, 3'd4, 3'd4);
    div_custom = 8'd1;
    period(2, 1, 3'd4, 3'd4);
    period(2, 1, 3'd4, 3'd4);
    div_custom = 8'd200;
    period(2, 1, 3'd4, 3'd4);
    rate_sel = 3'd0;
    period(200, 1, 3'd4, 3'd0);

    // 5: freeze with en=0 after cnt reaches 7 (clk_out=1, led=0 at that point)
    for (int c = 1; c <= 6; c++) edge_chk(c > 5, 1'b0, 3'd0);
    en = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk_in); #1;
      chk("frz_clk_out",  clk_out,  1'b1);
      chk("frz_led",      led,      1'b0);
      chk("frz_tick",     tick,     1'b0);
      chk("frz_rate_act", rate_act, 3'd0);
    end
    en         = 1'b1;
    rate_sel   = 3'd4;
    div_custom = 8'd9;
    period(10, 7, 3'd0, 3'd4);

    // 6: reset at cnt=6 with rate_sel=7 (maps to 0); fresh 10-cycle periods
    rate_sel = 3'd7;
    for (int c = 1; c <= 5; c++) edge_chk(c > 4, 1'b0, 3'd4);
    rst = 1'b1;
    @(posedge clk_in); #1;
    chk("rst2_clk_out",  clk_out,  1'b0);
    chk("rst2_tick",     tick,     1'b0);
    chk("rst2_led",      led,      1'b0);
    chk("rst2_rate_act", rate_act, 3'd0);
    prev_clk = 1'b0;
    rst      = 1'b0;
    period(10, 1, 3'd0, 3'd0);
    period(10, 1, 3'd0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
